// File: rtl/nios_ocimem_access_ctrl.sv
// Debug-RAM access sequencer for the JTAG debug module: decodes ocimem strobes into single-word RAM reads/writes.
// Request one cycle after the strobe; result visible the cycle after ram_ack; strobes while busy are dropped and flag an error.
module nios_ocimem_access_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, RD_WAIT, WR_WAIT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         mon_q, mon_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                any_strobe;
  logic                unused_jdo;

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mon_d   = mon_q;
    ready_d = ready_q;
    error_d = error_q;
    cnt_d   = cnt_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          addr_d  = jdo[ADDR_W+16:17];
          error_d = 1'b0;
          if (jdo[35]) begin
            state_d = RD_REQ;
            rd_d    = 1'b1;
            ready_d = 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          state_d = WR_REQ;
          wr_d    = 1'b1;
          ready_d = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          state_d = RD_REQ;
          rd_d    = 1'b1;
          ready_d = 1'b0;
        end
      end
      // Counter starts at TIMEOUT-1 so expiry lands after exactly TIMEOUT wait cycles.
      RD_REQ: begin
        state_d = RD_WAIT;
        cnt_d   = 8'(TIMEOUT - 1);
      end
      WR_REQ: begin
        state_d = WR_WAIT;
        cnt_d   = 8'(TIMEOUT - 1);
      end
      RD_WAIT, WR_WAIT: begin
        if (ram_ack) begin
          mon_d   = (state_q == RD_WAIT) ? ram_rdata : wdata_q;
          addr_d  = addr_q + ADDR_W'(1);
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && any_strobe) begin
      error_d = 1'b1;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mon_q   <= '0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mon_q   <= mon_d;
      ready_q <= ready_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ram_addr      = addr_q;
  assign ram_wdata     = wdata_q;
  assign ram_rd        = rd_q;
  assign ram_wr        = wr_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_nios_ocimem_access_ctrl.sv
// Bench for nios_ocimem_access_ctrl: directed scenarios then random commands against a transaction-level model.
module tb_nios_ocimem_access_ctrl;
  localparam int ADDR_W = 8;
  localparam int T      = 15;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              ta_a, ta_b, tna_a;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd, ram_wr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              ram_ack;
  logic [31:0]       mon;
  logic              ready, error, busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the architecturally visible state
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata, m_mon;
  logic              m_err;

  nios_ocimem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b), .take_no_action_ocimem_a(tna_a),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .MonDReg(mon), .monitor_ready(ready), .monitor_error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_stb(input logic [2:0] s);
    {ta_a, ta_b, tna_a} = s;
  endtask

  function automatic logic [37:0] mk_a(input logic [ADDR_W-1:0] a, input logic rd);
    logic [37:0] j;
    j = {6'($urandom), $urandom};
    j[ADDR_W+16:17] = a;
    j[35] = rd;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = {6'($urandom), $urandom};
    j[34:3] = d;
    return j;
  endfunction

  task automatic model_reset();
    m_addr = '0; m_wdata = '0; m_mon = '0; m_err = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, error, m_err);
    check({tag, "_mon"}, mon, m_mon);
    check({tag, "_rd"}, ram_rd, 1'b0);
    check({tag, "_wr"}, ram_wr, 1'b0);
  endtask

  // Entered and left at #1 after a rising edge; the command is driven in the current cycle.
  // ack_k: wait cycle (1 = the cycle right after the request) carrying ram_ack; > T means never.
  // coll_k: cycle relative to the request (0 = request cycle) in which a stray strobe arrives; -1 = none.
  task automatic do_cmd(input logic [2:0] stb, input logic [37:0] j, input int ack_k,
                        input int coll_k, input logic [2:0] coll_stb, input logic [31:0] rdata);
    logic access, is_rd, done;
    access = 1'b0; is_rd = 1'b0; done = 1'b0;
    jdo = j;
    set_stb(stb);
    if (stb[2]) begin
      m_addr = j[ADDR_W+16:17]; m_err = 1'b0; access = j[35]; is_rd = 1'b1;
    end else if (stb[1]) begin
      m_wdata = j[34:3]; access = 1'b1;
    end else if (stb[0]) begin
      access = 1'b1; is_rd = 1'b1;
    end
    @(posedge clk); #1;
    set_stb(3'b000);
    if (!access) begin
      check_idle("noacc");
      return;
    end
    check("req_rd", ram_rd, is_rd);
    check("req_wr", ram_wr, !is_rd);
    check("req_addr", ram_addr, m_addr);
    if (!is_rd) check("req_wdata", ram_wdata, m_wdata);
    check("req_ready", ready, 1'b0);
    check("req_busy", busy, 1'b1);
    if (coll_k == 0) set_stb(coll_stb);
    @(posedge clk); #1;
    set_stb(3'b000);
    if (coll_k == 0) m_err = 1'b1;
    for (int k = 1; k <= T; k++) begin
      check("wait_rd", ram_rd, 1'b0);
      check("wait_wr", ram_wr, 1'b0);
      check("wait_busy", busy, 1'b1);
      check("wait_ready", ready, 1'b0);
      check("wait_err", error, m_err);
      check("wait_addr", ram_addr, m_addr);
      if (!is_rd) check("wait_wdata", ram_wdata, m_wdata);
      if (coll_k == k) set_stb(coll_stb);
      if (ack_k == k) begin
        ram_ack = 1'b1; ram_rdata = rdata;
      end else begin
        ram_rdata = $urandom;
      end
      @(posedge clk); #1;
      set_stb(3'b000);
      ram_ack = 1'b0;
      if (coll_k == k) m_err = 1'b1;
      if (ack_k == k) begin
        m_mon = is_rd ? rdata : m_wdata;
        m_addr = m_addr + 1'b1;
        done = 1'b1;
        break;
      end
    end
    if (!done) m_err = 1'b1;
    check_idle("done");
  endtask

  task automatic idle_ack();
    ram_ack = 1'b1; ram_rdata = $urandom;
    @(posedge clk); #1;
    ram_ack = 1'b0;
    check_idle("idleack");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; jdo = '0; set_stb(3'b000); ram_ack = 1'b0; ram_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_idle("reset");
    check("reset_addr", ram_addr, '0);
    check("reset_wdata", ram_wdata, '0);

    // Load 0x10 and read; RAM acks one cycle after the request
    do_cmd(3'b100, mk_a(8'h10, 1'b1), 1, -1, 3'b000, 32'hDEADBEEF);
    check("ld_rd_mon", mon, 32'hDEADBEEF);
    // Next read confirms the address advanced to 0x11
    do_cmd(3'b001, '0, 2, -1, 3'b000, 32'h1111_0011);

    // Simultaneous a+b with no read: only the address loads
    do_cmd(3'b110, mk_a(8'hFE, 1'b0), 1, -1, 3'b000, 32'h0);
    // Burst write through the wrap
    do_cmd(3'b010, mk_b(32'd1), 1, -1, 3'b000, 32'h0);
    do_cmd(3'b010, mk_b(32'd2), 3, -1, 3'b000, 32'h0);
    do_cmd(3'b010, mk_b(32'd3), 1, -1, 3'b000, 32'h0);
    check("burst_mon", mon, 32'd3);
    check("burst_wrap_addr", ram_addr, 8'h01);

    // Timeout: no ack ever; error appears exactly T+2 cycles after the strobe
    do_cmd(3'b001, '0, T + 1, -1, 3'b000, 32'h0);
    check("timeout_err", error, 1'b1);
    do_cmd(3'b001, '0, 1, -1, 3'b000, 32'hCAFE_0001);
    do_cmd(3'b100, mk_a(8'h40, 1'b0), 1, -1, 3'b000, 32'h0);
    check("err_cleared", error, 1'b0);

    // Write strobe during RD_WAIT is dropped; the read still completes
    do_cmd(3'b001, '0, 3, 2, 3'b010, 32'h5A5A_A5A5);
    check("coll_mon", mon, 32'h5A5A_A5A5);

    // Reset in WR_WAIT, then a late ack
    jdo = mk_b(32'h1234_5678);
    set_stb(3'b010);
    @(posedge clk); #1; set_stb(3'b000);
    @(posedge clk); #1; reset_n = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1; ram_ack = 1'b1; ram_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1; ram_ack = 1'b0;
    model_reset();
    check_idle("rst_mid");
    check("rst_mid_addr", ram_addr, '0);
    check("rst_mid_wdata", ram_wdata, '0);
    do_cmd(3'b001, '0, 1, -1, 3'b000, 32'h0BAD_F00D);

    for (int i = 0; i < 250; i++) begin
      logic [2:0]  stb;
      logic [2:0]  cst;
      logic [37:0] j;
      int          ak, ck;
      stb = 3'($urandom_range(1, 7));
      cst = 3'($urandom_range(1, 7));
      j   = {6'($urandom), $urandom};
      ak  = ($urandom_range(0, 7) == 0) ? T + 1 : int'($urandom_range(1, 4));
      ck  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      if (ck > ak) ck = -1;
      do_cmd(stb, j, ak, ck, cst, $urandom);
      if ($urandom_range(0, 9) == 0) idle_ack();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
